// File: rtl/ace_fetch_queue.sv
// ---------------------------------------------------------------------------
// ace_fetch_queue
//
// Compacting instruction queue between fetch stage 1 and the decoder. Each
// cycle it takes one fetch packet of FETCH_W slots with an arbitrary valid
// mask. It squeezes out the holes and stores the valid slots in program
// order, then presents the oldest DEC_W entries to decode. A retire flush
// empties the queue in one cycle. full_o is the fetch-stall back-pressure.
//
// Optional feature macro: ACE_FETCHQ_PC_EN
//   defined   : a 64-bit PC is stored per entry and driven on deq_pc_o
//   undefined : no PC storage, deq_pc_o is tied to 0, enq_pc_i is ignored
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   enq_vld_i      fetch packet presented
//   enq_mask_i     per-slot valid (holes allowed)
//   enq_inst_i     slot k at [k*INST_W +: INST_W]
//   enq_pc_i       PC of slot 0; slot k has PC enq_pc_i + 4*k
//   flush_i        retire flush, highest priority
//   deq_cnt_i      head entries consumed this cycle (clamped to count)
//   deq_vld_o      lane i valid when i < count
//   deq_inst_o     lane i = entry rd_ptr+i
//   deq_pc_o       PC of lane i
//   count_o        occupied entries
//   full_o         free entries < FETCH_W (fetch stall)
//   empty_o        count_o == 0
//
// DEPTH must be at least 2 so that the pointers are non-empty vectors.
// ---------------------------------------------------------------------------
module ace_fetch_queue #(
    parameter int FETCH_W = 8,
    parameter int DEC_W   = 4,
    parameter int DEPTH   = 16,
    parameter int INST_W  = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enq_vld_i,
    input  logic [FETCH_W-1:0]          enq_mask_i,
    input  logic [FETCH_W*INST_W-1:0]   enq_inst_i,
    input  logic [63:0]                 enq_pc_i,
    input  logic                        flush_i,
    input  logic [$clog2(DEC_W):0]      deq_cnt_i,
    output logic [DEC_W-1:0]            deq_vld_o,
    output logic [DEC_W*INST_W-1:0]     deq_inst_o,
    output logic [DEC_W*64-1:0]         deq_pc_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DCW = $clog2(DEC_W) + 1;

    logic [INST_W-1:0] mem_inst [DEPTH];
`ifdef ACE_FETCHQ_PC_EN
    logic [63:0]       mem_pc   [DEPTH];
`endif

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [PW-1:0] slot_off [FETCH_W];
    logic [CW-1:0] n_enq;
    logic [CW-1:0] n_deq;
    logic [CW-1:0] enq_add;
    logic [CW-1:0] deq_req;
    logic [CW-1:0] free_cnt;
    logic          enq_fire;

    // Running popcount: slot k lands at wr_ptr + (number of valid slots below k).
    always_comb begin
        logic [CW-1:0] pos;
        pos = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            slot_off[k] = pos[PW-1:0];
            if (enq_mask_i[k]) begin
                pos = pos + CW'(1);
            end
        end
        n_enq = pos;
    end

    // full_o looks at the registered count only; a same-cycle dequeue does
    // not make room for the packet presented in that cycle.
    assign free_cnt = CW'(DEPTH) - count;
    assign full_o   = (free_cnt < CW'(FETCH_W));
    assign empty_o  = (count == '0);
    assign count_o  = count;

    assign enq_fire = enq_vld_i & ~full_o & ~flush_i & ~reset;
    assign enq_add  = enq_fire ? n_enq : '0;

    // Over-consumption is silently clamped to what is actually held.
    assign deq_req  = CW'(deq_cnt_i);
    assign n_deq    = (deq_req < count) ? deq_req : count;

    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // n_enq can equal DEPTH only when FETCH_W == DEPTH, where the
            // truncated add is the correct modular step of zero.
            wr_ptr <= wr_ptr + enq_add[PW-1:0];
            rd_ptr <= rd_ptr + n_deq[PW-1:0];
            count  <= count + enq_add - n_deq;
        end
    end

    // Storage has no reset; contents are only meaningful below count.
    always_ff @(posedge clock) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (enq_fire && enq_mask_i[k]) begin
                mem_inst[wr_ptr + slot_off[k]] <= enq_inst_i[k*INST_W +: INST_W];
`ifdef ACE_FETCHQ_PC_EN
                mem_pc[wr_ptr + slot_off[k]]   <= enq_pc_i + (64'(k) << 2);
`endif
            end
        end
    end

    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        deq_vld_o  = '0;
        deq_inst_o = '0;
`ifdef ACE_FETCHQ_PC_EN
        deq_pc_o   = '0;
`endif
        for (int i = 0; i < DEC_W; i++) begin
            idx          = rd_ptr + PW'(i);
            deq_vld_o[i] = (CW'(i) < count);
            deq_inst_o[i*INST_W +: INST_W] = mem_inst[idx];
`ifdef ACE_FETCHQ_PC_EN
            deq_pc_o[i*64 +: 64] = mem_pc[idx];
`endif
        end
    end

`ifndef ACE_FETCHQ_PC_EN
    assign deq_pc_o = '0;
    logic unused_pc;
    assign unused_pc = &{1'b0, enq_pc_i};
`endif

    logic unused_deq_width;
    assign unused_deq_width = (DCW == 0);

endmodule

// File: tb/tb_ace_fetch_queue.sv
// Directed bench for ace_fetch_queue with default parameters. PC checks
// follow ACE_FETCHQ_PC_EN: with the macro off every PC lane must read 0.
module tb_ace_fetch_queue;

    localparam int FETCH_W = 8;
    localparam int DEC_W   = 4;
    localparam int DEPTH   = 16;
    localparam int INST_W  = 32;

    logic                      clock;
    logic                      reset;
    logic                      enq_vld_i;
    logic [FETCH_W-1:0]        enq_mask_i;
    logic [FETCH_W*INST_W-1:0] enq_inst_i;
    logic [63:0]               enq_pc_i;
    logic                      flush_i;
    logic [2:0]                deq_cnt_i;
    logic [DEC_W-1:0]          deq_vld_o;
    logic [DEC_W*INST_W-1:0]   deq_inst_o;
    logic [DEC_W*64-1:0]       deq_pc_o;
    logic [4:0]                count_o;
    logic                      full_o;
    logic                      empty_o;

    ace_fetch_queue #(
        .FETCH_W(FETCH_W), .DEC_W(DEC_W), .DEPTH(DEPTH), .INST_W(INST_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enq_vld_i  (enq_vld_i),
        .enq_mask_i (enq_mask_i),
        .enq_inst_i (enq_inst_i),
        .enq_pc_i   (enq_pc_i),
        .flush_i    (flush_i),
        .deq_cnt_i  (deq_cnt_i),
        .deq_vld_o  (deq_vld_o),
        .deq_inst_o (deq_inst_o),
        .deq_pc_o   (deq_pc_o),
        .count_o    (count_o),
        .full_o     (full_o),
        .empty_o    (empty_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [95:0] sbq [$];
    int          pkt;
    int          nd;
    bit          acc;
    logic [63:0] base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int p, input int slot);
        return 32'hA000_0000 | (32'(p) << 8) | 32'(slot);
    endfunction

    function automatic logic [FETCH_W*INST_W-1:0] pack(input int p);
        logic [FETCH_W*INST_W-1:0] v;
        v = '0;
        for (int k = 0; k < FETCH_W; k++) v[k*INST_W +: INST_W] = mk(p, k);
        return v;
    endfunction

    function automatic logic [63:0] epc(input logic [63:0] pc);
`ifdef ACE_FETCHQ_PC_EN
        return pc;
`else
        return pc & 64'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        enq_vld_i  = 1'b0;
        enq_mask_i = '0;
        flush_i    = 1'b0;
        deq_cnt_i  = '0;
    endtask

    task automatic drive_enq(input logic [7:0] mask, input int p, input logic [63:0] pc);
        enq_vld_i  = 1'b1;
        enq_mask_i = mask;
        enq_inst_i = pack(p);
        enq_pc_i   = pc;
    endtask

    task automatic lane_chk(input string tag, input int i, input logic [31:0] inst, input logic [63:0] pc);
        chk($sformatf("%s lane%0d inst", tag, i), 64'(deq_inst_o[i*INST_W +: INST_W]), 64'(inst));
        chk($sformatf("%s lane%0d pc", tag, i), deq_pc_o[i*64 +: 64], epc(pc));
    endtask

    initial begin
        idle();
        enq_inst_i = '0;
        enq_pc_i   = '0;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset then idle for three cycles
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("idle count", 64'(count_o), 64'd0);
            chk("idle empty", 64'(empty_o), 64'd1);
            chk("idle full", 64'(full_o), 64'd0);
            chk("idle vld", 64'(deq_vld_o), 64'd0);
        end

        // Compaction: mask 1010_0101 -> slots 0,2,5,7
        drive_enq(8'b1010_0101, 1, 64'h1000);
        tick();
        idle();
        chk("cmp count", 64'(count_o), 64'd4);
        chk("cmp vld", 64'(deq_vld_o), 64'hF);
        lane_chk("cmp", 0, mk(1, 0), 64'h1000);
        lane_chk("cmp", 1, mk(1, 2), 64'h1008);
        lane_chk("cmp", 2, mk(1, 5), 64'h1014);
        lane_chk("cmp", 3, mk(1, 7), 64'h101C);
        deq_cnt_i = 3'd4;
        tick();
        idle();
        chk("cmp drained", 64'(empty_o), 64'd1);

        // Fill and back-pressure
        drive_enq(8'hFF, 2, 64'h3000);
        tick();
        chk("fill8 count", 64'(count_o), 64'd8);
        chk("fill8 full", 64'(full_o), 64'd0);
        drive_enq(8'h01, 3, 64'h4000);
        tick();
        idle();
        chk("fill9 count", 64'(count_o), 64'd9);
        chk("fill9 full", 64'(full_o), 64'd1);
        drive_enq(8'hFF, 4, 64'h5000);
        tick();
        idle();
        chk("drop count", 64'(count_o), 64'd9);
        deq_cnt_i = 3'd1;
        tick();
        idle();
        chk("deq1 count", 64'(count_o), 64'd8);
        chk("deq1 full", 64'(full_o), 64'd0);
        lane_chk("deq1", 0, mk(2, 1), 64'h3004);
        lane_chk("deq1", 3, mk(2, 4), 64'h3010);
        deq_cnt_i = 3'd4;
        tick();
        idle();
        lane_chk("fill", 0, mk(2, 5), 64'h3014);
        lane_chk("fill", 2, mk(2, 7), 64'h301C);
        lane_chk("fill", 3, mk(3, 0), 64'h4000);
        deq_cnt_i = 3'd4;
        tick();
        idle();
        chk("fill drained", 64'(count_o), 64'd0);

        // Wrap with simultaneous traffic against a scoreboard
        pkt  = 10;
        base = 64'h2000;
        for (int c = 0; c < 20; c++) begin
            chk("wrap count", 64'(count_o), 64'(sbq.size()));
            for (int i = 0; i < DEC_W && i < sbq.size(); i++)
                lane_chk("wrap", i, sbq[i][31:0], sbq[i][95:32]);
            nd  = (sbq.size() >= 4) ? 4 : 0;
            acc = (DEPTH - sbq.size()) >= FETCH_W;
            drive_enq(8'hFF, pkt, base);
            deq_cnt_i = 3'(nd);
            tick();
            repeat (nd) void'(sbq.pop_front());
            if (acc)
                for (int k = 0; k < FETCH_W; k++) sbq.push_back({base + 64'(4*k), mk(pkt, k)});
            pkt++;
            base = base + 64'd32;
        end
        idle();
        while (sbq.size() > 0) begin
            chk("drain count", 64'(count_o), 64'(sbq.size()));
            for (int i = 0; i < DEC_W && i < sbq.size(); i++)
                lane_chk("drain", i, sbq[i][31:0], sbq[i][95:32]);
            nd = (sbq.size() >= 4) ? 4 : sbq.size();
            deq_cnt_i = 3'(nd);
            tick();
            repeat (nd) void'(sbq.pop_front());
        end
        idle();
        chk("wrap empty", 64'(empty_o), 64'd1);

        // Over-dequeue clamp, PC wrap at 2^64
        drive_enq(8'h03, 40, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        idle();
        chk("clamp count", 64'(count_o), 64'd2);
        chk("clamp vld", 64'(deq_vld_o), 64'h3);
        lane_chk("pcwrap", 0, mk(40, 0), 64'hFFFF_FFFF_FFFF_FFFC);
        lane_chk("pcwrap", 1, mk(40, 1), 64'h0);
        deq_cnt_i = 3'd4;
        tick();
        idle();
        chk("clamp count0", 64'(count_o), 64'd0);
        chk("clamp empty", 64'(empty_o), 64'd1);

        // Flush collision at count 10
        drive_enq(8'hFF, 50, 64'h6000);
        tick();
        drive_enq(8'h03, 51, 64'h7000);
        tick();
        chk("pre-flush count", 64'(count_o), 64'd10);
        drive_enq(8'hFF, 52, 64'h8000);
        flush_i   = 1'b1;
        deq_cnt_i = 3'd2;
        tick();
        idle();
        chk("flush count", 64'(count_o), 64'd0);
        chk("flush vld", 64'(deq_vld_o), 64'd0);
        chk("flush empty", 64'(empty_o), 64'd1);
        tick();
        chk("flush stays empty", 64'(count_o), 64'd0);

        // Flush with room: packet must still be ignored
        drive_enq(8'h03, 54, 64'h9000);
        tick();
        drive_enq(8'hFF, 55, 64'hA000);
        flush_i = 1'b1;
        tick();
        idle();
        chk("flush2 count", 64'(count_o), 64'd0);
        drive_enq(8'h01, 53, 64'hB000);
        tick();
        idle();
        chk("post-flush count", 64'(count_o), 64'd1);
        lane_chk("post-flush", 0, mk(53, 0), 64'hB000);

        // Reset mid-operation drops the in-flight packet
        drive_enq(8'hFF, 60, 64'hC000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        chk("rst count", 64'(count_o), 64'd0);
        chk("rst empty", 64'(empty_o), 64'd1);
        chk("rst full", 64'(full_o), 64'd0);
        tick();
        chk("rst stays empty", 64'(deq_vld_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
